// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared types and constants for the instruction-fetch stage
package if_stage_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 64;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [INST_W-1:0] NOP_INST     = 32'h0000_0013;

`ifdef IF_MISALIGN_CHECK_EN
    localparam int ENTRY_W = INST_W + ADDR_W + 1;
`else
    localparam int ENTRY_W = INST_W + ADDR_W;
`endif

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return pc & ~64'h3;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory request/response channel
interface if_stage_if;
    import if_stage_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_inst_fifo.sv
// rtl/if_inst_fifo.sv - registered instruction buffer with clear, simultaneous push/pop
module if_inst_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [PW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - fetch stage top: PC, imem requests, instruction FIFO; IF_MISALIGN_CHECK_EN adds misalign trap entry
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    if_stage_if.master        imem,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic              inst_misalign
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inflight_q, pc_inflight_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic              outstanding_q, outstanding_d;
    logic              drop_q, drop_d;
    logic              hold_q, hold_d;
    logic              stale_q, stale_d;

    logic              halt;
    logic              push_nop;
    logic [ADDR_W-1:0] redirect_load;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [PW:0]       fifo_count;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_head;
    logic [PW+1:0]     used;
    logic              credit_ok, req_valid, accept, rsp_take;
    logic [ADDR_W-1:0] req_addr;

`ifdef IF_MISALIGN_CHECK_EN
    logic halt_q, halt_d, nop_q, nop_d;
    logic redirect_mis;

    assign redirect_mis  = (redirect_pc[1:0] != 2'b00);
    assign halt          = halt_q;
    assign push_nop      = nop_q & ~redirect_valid;
    assign redirect_load = redirect_pc;
    assign fifo_wdata    = push_nop ? {1'b1, NOP_INST, pc_q}
                                    : {1'b0, imem.imem_rsp_data, pc_inflight_q};
    assign inst_misalign = fifo_head[ENTRY_W-1];
`else
    assign halt          = 1'b0;
    assign push_nop      = 1'b0;
    assign redirect_load = align_pc(redirect_pc);
    assign fifo_wdata    = {imem.imem_rsp_data, pc_inflight_q};
`endif

    // Credits cover buffered entries plus the response still in flight.
    assign used      = {1'b0, fifo_count} + {{(PW+1){1'b0}}, outstanding_q};
    assign credit_ok = ~fifo_full & (used < (PW+2)'(FIFO_DEPTH));

    // A presented request is held until accepted, even after a redirect.
    assign req_addr  = hold_q ? hold_addr_q : pc_q;
    assign req_valid = (state_q == IF_REQ) & (hold_q | (credit_ok & ~halt));
    assign accept    = req_valid & imem.imem_req_ready;
    assign rsp_take  = (state_q == IF_WAIT) & imem.imem_rsp_valid;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = req_addr;

    assign fifo_push  = (rsp_take & ~drop_q & ~redirect_valid) | push_nop;
    assign fifo_pop   = inst_valid & inst_ready;
    assign inst_valid = ~fifo_empty;
    assign inst       = fifo_head[INST_W+ADDR_W-1:ADDR_W];
    assign inst_pc    = fifo_head[ADDR_W-1:0];

    if_inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (redirect_valid),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_inflight_d = pc_inflight_q;
        hold_addr_d   = hold_addr_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        hold_d        = hold_q;
        stale_d       = stale_q;
`ifdef IF_MISALIGN_CHECK_EN
        halt_d        = halt_q;
        nop_d         = 1'b0;
`endif

        // A stray response with nothing outstanding is the one reset orphaned.
        if (imem.imem_rsp_valid && !outstanding_q) begin
            drop_d = 1'b0;
        end

        case (state_q)
            IF_IDLE: state_d = IF_REQ;
            IF_REQ: begin
                if (accept) begin
                    outstanding_d = 1'b1;
                    pc_inflight_d = req_addr;
                    drop_d        = drop_q | stale_q;
                    hold_d        = 1'b0;
                    stale_d       = 1'b0;
                    if (!stale_q) begin
                        pc_d = pc_q + 64'd4;
                    end
                    state_d = IF_WAIT;
                end else if (req_valid) begin
                    hold_d      = 1'b1;
                    hold_addr_d = req_addr;
                end
            end
            IF_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    outstanding_d = 1'b0;
                    drop_d        = 1'b0;
                    state_d       = IF_REQ;
                end
            end
            default: state_d = IF_IDLE;
        endcase

        if (redirect_valid) begin
            pc_d = redirect_load;
            if ((outstanding_q && !rsp_take) || accept) begin
                drop_d = 1'b1;
            end
            if (hold_d) begin
                stale_d = 1'b1;
            end
`ifdef IF_MISALIGN_CHECK_EN
            halt_d = redirect_mis;
            nop_d  = redirect_mis;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IF_IDLE;
            pc_q          <= RESET_PC;
            pc_inflight_q <= '0;
            hold_addr_q   <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= outstanding_q;
            hold_q        <= 1'b0;
            stale_q       <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
            halt_q        <= 1'b0;
            nop_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_inflight_q <= pc_inflight_d;
            hold_addr_q   <= hold_addr_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            hold_q        <= hold_d;
            stale_q       <= stale_d;
`ifdef IF_MISALIGN_CHECK_EN
            halt_q        <= halt_d;
            nop_q         <= nop_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with memory model and delivery scoreboard
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
`ifdef IF_MISALIGN_CHECK_EN
    logic        inst_misalign;
`endif

    always #5 clock = ~clock;

    if_stage_if imem_bus ();

    if_stage dut (
        .clock          (clock),
        .reset          (reset),
        .imem           (imem_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .inst_misalign  (inst_misalign)
`endif
    );

    typedef struct {
        logic        inst_ready;
        logic        mem_ready;
        logic        req_valid;
        logic [63:0] req_addr;
        logic        inst_valid;
        logic [63:0] inst_pc;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        mis;
    } exp_t;

    vec_t        vecs [8];
    exp_t        exp_q [$];
    logic [63:0] exp_fetch;
    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    int          accepts = 0;
    logic [63:0] last_acc_addr;
    logic [63:0] last_del_pc;
    logic [31:0] last_del_inst;
    bit          mem_pend;
    int          mem_cnt;
    int          mem_lat = 1;
    logic [63:0] mem_addr;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_fetch = RESET_PC_DEF;
        mem_pend  = 1'b0;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = '0;
    endtask

    // Called mid-cycle: score this cycle's handshakes, then cross the edge.
    task automatic advance();
        exp_t e;
        if (inst_valid && inst_ready) begin
            delivered++;
            last_del_pc   = inst_pc;
            last_del_inst = inst;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h expected no delivery", inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_inst", 64'(inst), 64'(e.inst));
                chk("sb_pc", inst_pc, e.pc);
`ifdef IF_MISALIGN_CHECK_EN
                chk("sb_misalign", 64'(inst_misalign), 64'(e.mis));
`endif
            end
        end
        if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
            accepts++;
            last_acc_addr = imem_bus.imem_req_addr;
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = imem_bus.imem_req_addr;
            if (imem_bus.imem_req_addr == exp_fetch) begin
                exp_q.push_back('{inst_of(exp_fetch), exp_fetch, 1'b0});
                exp_fetch = exp_fetch + 64'd4;
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
`ifdef IF_MISALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                exp_q.push_back('{NOP_INST, redirect_pc, 1'b1});
                exp_fetch = 64'h1;
            end else begin
                exp_fetch = redirect_pc;
            end
`else
            exp_fetch = redirect_pc & ~64'h3;
`endif
        end
        @(posedge clock);
        #1;
        redirect_valid = 1'b0;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = '0;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_bus.imem_rsp_valid = 1'b1;
                imem_bus.imem_rsp_data  = inst_of(mem_addr);
                mem_pend = 1'b0;
            end
        end
    endtask

    task automatic tick();
        #2;
        advance();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        model_reset();
        reset = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        int a0 = accepts;
        for (int i = 0; i < 30 && accepts == a0; i++) tick();
        checks++;
        if (accepts == a0) begin
            errors++;
            $display("FAIL %s: got no request accepted, expected one within 30 cycles", name);
        end
    endtask

    task automatic wait_delivery(input string name);
        int d0 = delivered;
        for (int i = 0; i < 40 && delivered == d0; i++) tick();
        checks++;
        if (delivered == d0) begin
            errors++;
            $display("FAIL %s: got no delivery, expected one within 40 cycles", name);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held_addr;
        int          a0, d0;
        bit          found;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 64'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 64'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 64'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 64'h0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008};

        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_bus.imem_req_ready = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_req_valid", 64'(imem_bus.imem_req_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);

        // Straight-line fetch from reset, one cycle memory.
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            inst_ready = vecs[i].inst_ready;
            imem_bus.imem_req_ready = vecs[i].mem_ready;
            #2;
            chk($sformatf("vec%0d_req_valid", i), 64'(imem_bus.imem_req_valid), 64'(vecs[i].req_valid));
            if (vecs[i].req_valid)
                chk($sformatf("vec%0d_req_addr", i), imem_bus.imem_req_addr, vecs[i].req_addr);
            chk($sformatf("vec%0d_inst_valid", i), 64'(inst_valid), 64'(vecs[i].inst_valid));
            if (vecs[i].inst_valid)
                chk($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].inst_pc);
            advance();
        end

        // Backpressure fills exactly FIFO_DEPTH entries.
        inst_ready = 1'b0;
        do_reset();
        a0 = accepts;
        repeat (10) tick();
        chk("bp_accepts", 64'(accepts - a0), 64'd2);
        chk("bp_inst_valid", 64'(inst_valid), 64'd1);
        chk("bp_req_valid", 64'(imem_bus.imem_req_valid), 64'd0);
        d0 = delivered;
        inst_ready = 1'b1;
        wait_accept("bp_resume");
        chk("bp_resume_addr", last_acc_addr, 64'h8000_0008);
        chk("bp_drained", 64'(delivered - d0), 64'd2);

        // Redirect while a slow response is outstanding.
        mem_lat = 3;
        wait_accept("rd_out_setup");
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        tick();
        chk("rd_out_flush", 64'(inst_valid), 64'd0);
        wait_delivery("rd_out_deliver");
        chk("rd_out_first_pc", last_del_pc, 64'h8000_1000);

        // Redirect coinciding with a pop and a response.
        mem_lat = 1;
        repeat (4) tick();
        inst_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (inst_valid && imem_bus.imem_rsp_valid) found = 1'b1;
            else tick();
        end
        chk("rd_pop_found", 64'(found), 64'd1);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        d0 = delivered;
        tick();
        chk("rd_pop_counted", 64'(delivered - d0), 64'd1);
        chk("rd_pop_flush", 64'(inst_valid), 64'd0);
        wait_delivery("rd_pop_deliver");
        chk("rd_pop_first_pc", last_del_pc, 64'h8000_2000);

        // Redirect while a request is stalled by imem_req_ready.
        imem_bus.imem_req_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (imem_bus.imem_req_valid) found = 1'b1;
            else tick();
        end
        chk("hold_found", 64'(found), 64'd1);
        held_addr = imem_bus.imem_req_addr;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                redirect_valid = 1'b1;
                redirect_pc    = 64'h8000_3000;
            end
            chk($sformatf("hold%0d_valid", c), 64'(imem_bus.imem_req_valid), 64'd1);
            chk($sformatf("hold%0d_addr", c), imem_bus.imem_req_addr, held_addr);
            tick();
        end
        imem_bus.imem_req_ready = 1'b1;
        a0 = accepts;
        tick();
        chk("hold_accept", 64'(accepts - a0), 64'd1);
        chk("hold_accept_addr", last_acc_addr, held_addr);
        wait_accept("hold_next");
        chk("hold_next_addr", last_acc_addr, 64'h8000_3000);
        wait_delivery("hold_deliver");
        chk("hold_first_pc", last_del_pc, 64'h8000_3000);

`ifdef IF_MISALIGN_CHECK_EN
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0002;
        tick();
        wait_delivery("mis_deliver");
        chk("mis_pc", last_del_pc, 64'h8000_0002);
        chk("mis_inst", 64'(last_del_inst), 64'h13);
        a0 = accepts;
        repeat (10) tick();
        chk("mis_halt", 64'(accepts - a0), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_5000;
        tick();
        wait_accept("mis_restart");
        chk("mis_restart_addr", last_acc_addr, 64'h8000_5000);
`else
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_4002;
        tick();
        wait_accept("align_req");
        chk("align_addr", last_acc_addr, 64'h8000_4000);
        wait_delivery("align_deliver");
        chk("align_pc", last_del_pc, 64'h8000_4000);
`endif

        repeat (6) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
